// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the float-to-integer converter:
// rounding modes, converter FSM states and integer saturation limits.
package fpu;

    typedef enum logic [1:0] {
        FPU_RM_EVEN = 2'd0,
        FPU_RM_DOWN = 2'd1,
        FPU_RM_UP   = 2'd2,
        FPU_RM_ZERO = 2'd3
    } fpu_round_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fpu_f2i_state_t;

    localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

    // NaN saturates like a positive overflow, so callers pass sign & !nan as neg.
    function automatic logic [31:0] f2i_saturate(input logic neg, input logic is_signed);
        if (!neg) begin
            return is_signed ? INT32_MAX : UINT32_MAX;
        end
        return is_signed ? INT32_MIN : 32'h0000_0000;
    endfunction

endpackage

// File: rtl/fpu_f2i_round_decide.sv
// Combinational round-increment decision for the float-to-integer converter,
// given the sign, the integer LSB and the guard/sticky bits of the discarded fraction.
module fpu_f2i_round_decide
    import fpu::*;
(
    input  logic            sign,
    input  logic            lsb,
    input  logic            guard,
    input  logic            sticky,
    input  fpu_round_mode_t mode,
    output logic            inc
);

    always_comb begin
        inc = 1'b0;
        case (mode)
            FPU_RM_EVEN: inc = guard & (sticky | lsb);
            FPU_RM_DOWN: inc = sign & (guard | sticky);
            FPU_RM_UP:   inc = ~sign & (guard | sticky);
            default:     inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_float_to_int.sv
// Multi-cycle IEEE-754 binary32 to int32/uint32 converter, one shift position per cycle.
// Exception flags are driven only when FPU_FLOAT_TO_INT_FLAGS_EN is defined; otherwise tied to 0.
module fpu_float_to_int
    import fpu::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_float,
    input  logic            in_signed,
    input  fpu_round_mode_t in_round_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic            out_invalid,
    output logic            out_inexact
);

`ifdef FPU_FLOAT_TO_INT_FLAGS_EN
    localparam logic FLAGS_EN = 1'b1;
`else
    localparam logic FLAGS_EN = 1'b0;
`endif

    fpu_f2i_state_t  state_reg;
    fpu_round_mode_t mode_reg;
    logic            sign_reg;
    logic            signed_reg;
    logic            special_reg;
    logic            nan_reg;
    logic            left_reg;
    logic [4:0]      shift_cnt_reg;
    logic [32:0]     mag_reg;
    logic            guard_reg;
    logic            sticky_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;
    logic [31:0]     result_reg;
    logic            invalid_reg;
    logic            inexact_reg;

    // Operand decode, evaluated on the accept cycle. Biased exponent 150 is e = 23.
    logic [7:0]  acc_exp;
    logic [22:0] acc_mant;
    logic        acc_nonzero;
    logic        acc_special;
    logic        acc_tiny;
    logic        acc_left;
    logic [4:0]  acc_cnt;
    logic [32:0] acc_mag;

    always_comb begin
        acc_exp     = in_float[30:23];
        acc_mant    = in_float[22:0];
        acc_nonzero = |in_float[30:0];
        acc_special = (acc_exp >= 8'd159);
        acc_tiny    = (acc_exp <= 8'd125);
        acc_left    = (acc_exp > 8'd150);
        acc_cnt     = 5'd0;
        acc_mag     = 33'd0;
        if (!acc_special && !acc_tiny) begin
            acc_mag = {9'd0, 1'b1, acc_mant};
            acc_cnt = acc_left ? 5'(acc_exp - 8'd150) : 5'(8'd150 - acc_exp);
        end
    end

    logic        round_inc;
    logic [32:0] rounded;
    logic        out_of_range;
    logic        round_invalid;
    logic        round_inexact;
    logic [31:0] round_result;

    fpu_f2i_round_decide u_round_decide (
        .sign   (sign_reg),
        .lsb    (mag_reg[0]),
        .guard  (guard_reg),
        .sticky (sticky_reg),
        .mode   (mode_reg),
        .inc    (round_inc)
    );

    // Range check is done on the rounded magnitude; a negative value that rounds
    // to magnitude 0 is a legal unsigned 0.
    always_comb begin
        rounded = mag_reg + {32'd0, round_inc};
        if (signed_reg) begin
            out_of_range = sign_reg ? (rounded > 33'h0_8000_0000) : (rounded > 33'h0_7FFF_FFFF);
        end else begin
            out_of_range = sign_reg ? (rounded != 33'd0) : rounded[32];
        end
        round_invalid = special_reg | out_of_range;
        round_inexact = ~round_invalid & (guard_reg | sticky_reg);
        if (round_invalid) begin
            round_result = f2i_saturate(sign_reg & ~nan_reg, signed_reg);
        end else if (sign_reg && signed_reg) begin
            round_result = 32'd0 - rounded[31:0];
        end else begin
            round_result = rounded[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mode_reg      <= FPU_RM_EVEN;
            sign_reg      <= 1'b0;
            signed_reg    <= 1'b0;
            special_reg   <= 1'b0;
            nan_reg       <= 1'b0;
            left_reg      <= 1'b0;
            shift_cnt_reg <= 5'd0;
            mag_reg       <= 33'd0;
            guard_reg     <= 1'b0;
            sticky_reg    <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= 32'd0;
            invalid_reg   <= 1'b0;
            inexact_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg      <= in_float[31];
                        signed_reg    <= in_signed;
                        mode_reg      <= in_round_mode;
                        special_reg   <= acc_special;
                        nan_reg       <= (acc_exp == 8'hFF) && (acc_mant != 23'd0);
                        left_reg      <= acc_left;
                        shift_cnt_reg <= acc_cnt;
                        mag_reg       <= acc_mag;
                        guard_reg     <= 1'b0;
                        sticky_reg    <= acc_tiny & acc_nonzero;
                        in_ready_reg  <= 1'b0;
                        state_reg     <= (acc_cnt != 5'd0) ? SHIFT : ROUND;
                    end
                end
                SHIFT: begin
                    if (left_reg) begin
                        mag_reg <= {mag_reg[31:0], 1'b0};
                    end else begin
                        mag_reg    <= {1'b0, mag_reg[32:1]};
                        guard_reg  <= mag_reg[0];
                        sticky_reg <= sticky_reg | guard_reg;
                    end
                    if (shift_cnt_reg == 5'd1) begin
                        state_reg <= ROUND;
                    end else begin
                        shift_cnt_reg <= shift_cnt_reg - 5'd1;
                    end
                end
                ROUND: begin
                    result_reg    <= round_result;
                    invalid_reg   <= FLAGS_EN & round_invalid;
                    inexact_reg   <= FLAGS_EN & round_inexact;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_result  = result_reg;
    assign out_invalid = invalid_reg;
    assign out_inexact = inexact_reg;

endmodule

// File: tb/tb_fpu_float_to_int.sv
// Self-checking bench for fpu_float_to_int: directed vectors pinned by hand plus
// randomized operands, all checked against an exact-arithmetic conversion model.
`timescale 1ns/1ps
module tb_fpu_float_to_int;
    import fpu::*;

`ifdef FPU_FLOAT_TO_INT_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    localparam longint I32_MIN_L = -64'sd2147483648;
    localparam longint I32_MAX_L = 64'sd2147483647;
    localparam longint U32_MAX_L = 64'sd4294967295;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_float = 32'd0;
    logic            in_signed = 1'b0;
    fpu_round_mode_t in_round_mode = FPU_RM_EVEN;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_result;
    logic            out_invalid;
    logic            out_inexact;

    always #5 clk = ~clk;

    fpu_float_to_int dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_float      (in_float),
        .in_signed     (in_signed),
        .in_round_mode (in_round_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_invalid   (out_invalid),
        .out_inexact   (out_inexact)
    );

    typedef struct {
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          lat;
    } ref_t;

    typedef struct {
        logic [31:0]     f;
        logic            sg;
        fpu_round_mode_t m;
        ref_t            r;
    } txn_t;

    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Exact conversion: integer part plus remainder compared against one half.
    function automatic ref_t model(input logic [31:0] f, input logic sg, input fpu_round_mode_t m);
        ref_t r;
        int ex, e, s;
        logic neg, nan, frac_nz, above, tie, up, bad;
        longint unsigned sig, ip, rem, half;
        longint v;
        ex  = int'(f[30:23]);
        e   = ex - 127;
        neg = f[31];
        nan = (ex == 255) && (f[22:0] != 23'd0);
        sig = {40'd0, 1'b1, f[22:0]};
        ip = 0; rem = 0; half = 0;
        frac_nz = 0; above = 0; tie = 0; bad = 0; up = 0;
        r.lat = 2;
        if (ex == 255 || e >= 32) begin
            bad = 1;
        end else if (f[30:0] == 31'd0) begin
            ip = 0;
        end else if (e < -1) begin
            frac_nz = 1;
        end else if (e >= 23) begin
            ip = sig << (e - 23);
            r.lat = 2 + e - 23;
        end else begin
            s       = 23 - e;
            ip      = sig >> s;
            rem     = sig - (ip << s);
            half    = 64'd1 << (s - 1);
            frac_nz = (rem != 0);
            above   = (rem > half);
            tie     = (rem == half);
            r.lat   = 2 + s;
        end
        case (m)
            FPU_RM_EVEN: up = above || (tie && ip[0]);
            FPU_RM_DOWN: up = neg && frac_nz;
            FPU_RM_UP:   up = !neg && frac_nz;
            default:     up = 0;
        endcase
        ip = ip + {63'd0, up};
        v  = neg ? -longint'(ip) : longint'(ip);
        if (!bad) begin
            bad = sg ? (v < I32_MIN_L || v > I32_MAX_L) : (v < 0 || v > U32_MAX_L);
        end
        if (bad) begin
            r.inv = 1;
            r.inx = 0;
            if (nan || !neg) r.res = sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            else             r.res = sg ? 32'h8000_0000 : 32'h0000_0000;
        end else begin
            r.inv = 0;
            r.inx = frac_nz;
            r.res = v[31:0];
        end
        return r;
    endfunction

    // Compare process: sampled on the falling edge, away from the active edge.
    initial begin : monitor
        int   cyc;
        bit   active;
        bit   seen;
        int   ntx;
        txn_t t;
        cyc = 0; active = 0; seen = 0; ntx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                active = 0;
            end else begin
                if (active) cyc++;
                if (in_valid && in_ready) begin
                    t.f  = in_float;
                    t.sg = in_signed;
                    t.m  = in_round_mode;
                    t.r  = model(in_float, in_signed, in_round_mode);
                    exp_q.push_back(t);
                    cyc = 0; active = 1; seen = 0;
                end else if (active) begin
                    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", {31'd0, out_valid}, 32'd0);
                    end else begin
                        t = exp_q[0];
                        chk("result", out_result, t.r.res);
                        chk("invalid", {31'd0, out_invalid}, {31'd0, FLAGS_ON & t.r.inv});
                        chk("inexact", {31'd0, out_inexact}, {31'd0, FLAGS_ON & t.r.inx});
                        if (!seen) begin
                            chk("latency", cyc, t.r.lat);
                            seen = 1;
                        end
                        if (out_ready) begin
                            $display("txn %0d f=%h signed=%0b mode=%0d result=%h inv=%0b inx=%0b lat=%0d",
                                     ntx, t.f, t.sg, t.m, out_result, out_invalid, out_inexact, t.r.lat);
                            ntx++;
                            void'(exp_q.pop_front());
                            active = 0;
                        end
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the result handshake.
    task automatic run_op(input logic [31:0] f, input logic sg, input fpu_round_mode_t m, input int stall);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        in_float = f; in_signed = sg; in_round_mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0]     f;
        logic            sg;
        fpu_round_mode_t m;
        logic [31:0]     res;
        logic            inv;
        logic            inx;
        int              lat;
    } vec_t;

    vec_t dir_q[$];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        vec_t            v;
        ref_t            r;
        logic [31:0]     f;
        logic [7:0]      ex8;
        logic [22:0]     mant;
        fpu_round_mode_t m;

        dir_q.push_back('{f:32'h3FC0_0000, sg:1'b1, m:FPU_RM_EVEN, res:32'h0000_0002, inv:1'b0, inx:1'b1, lat:25});
        dir_q.push_back('{f:32'hC020_0000, sg:1'b1, m:FPU_RM_EVEN, res:32'hFFFF_FFFE, inv:1'b0, inx:1'b1, lat:24});
        dir_q.push_back('{f:32'hC020_0000, sg:1'b1, m:FPU_RM_DOWN, res:32'hFFFF_FFFD, inv:1'b0, inx:1'b1, lat:24});
        dir_q.push_back('{f:32'hC020_0000, sg:1'b1, m:FPU_RM_ZERO, res:32'hFFFF_FFFE, inv:1'b0, inx:1'b1, lat:24});
        dir_q.push_back('{f:32'h4F00_0000, sg:1'b1, m:FPU_RM_EVEN, res:32'h7FFF_FFFF, inv:1'b1, inx:1'b0, lat:10});
        dir_q.push_back('{f:32'h4F00_0000, sg:1'b0, m:FPU_RM_EVEN, res:32'h8000_0000, inv:1'b0, inx:1'b0, lat:10});
        dir_q.push_back('{f:32'h7FC0_0000, sg:1'b1, m:FPU_RM_EVEN, res:32'h7FFF_FFFF, inv:1'b1, inx:1'b0, lat:2});
        dir_q.push_back('{f:32'hFF80_0000, sg:1'b0, m:FPU_RM_EVEN, res:32'h0000_0000, inv:1'b1, inx:1'b0, lat:2});
        dir_q.push_back('{f:32'hBE80_0000, sg:1'b0, m:FPU_RM_ZERO, res:32'h0000_0000, inv:1'b0, inx:1'b1, lat:2});
        dir_q.push_back('{f:32'hBE80_0000, sg:1'b0, m:FPU_RM_UP,   res:32'h0000_0000, inv:1'b0, inx:1'b1, lat:2});
        dir_q.push_back('{f:32'hBE80_0000, sg:1'b0, m:FPU_RM_DOWN, res:32'h0000_0000, inv:1'b1, inx:1'b0, lat:2});
        dir_q.push_back('{f:32'h0000_0000, sg:1'b1, m:FPU_RM_UP,   res:32'h0000_0000, inv:1'b0, inx:1'b0, lat:2});
        dir_q.push_back('{f:32'h4B00_0000, sg:1'b0, m:FPU_RM_EVEN, res:32'h0080_0000, inv:1'b0, inx:1'b0, lat:2});
        dir_q.push_back('{f:32'h3F00_0000, sg:1'b1, m:FPU_RM_EVEN, res:32'h0000_0000, inv:1'b0, inx:1'b1, lat:26});
        dir_q.push_back('{f:32'h3F00_0000, sg:1'b1, m:FPU_RM_UP,   res:32'h0000_0001, inv:1'b0, inx:1'b1, lat:26});
        dir_q.push_back('{f:32'hCF00_0000, sg:1'b1, m:FPU_RM_EVEN, res:32'h8000_0000, inv:1'b0, inx:1'b0, lat:10});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_result", out_result, 32'd0);
        chk("reset_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (dir_q[i]) begin
            v = dir_q[i];
            r = model(v.f, v.sg, v.m);
            chk("model_res", r.res, v.res);
            chk("model_flags", {30'd0, r.inv, r.inx}, {30'd0, v.inv, v.inx});
            chk("model_lat", r.lat, v.lat);
            run_op(v.f, v.sg, v.m, 0);
        end

        // Output back-pressure: result held for 5 stalled cycles
        run_op(32'h3FC0_0000, 1'b1, FPU_RM_EVEN, 5);
        run_op(32'hC020_0000, 1'b1, FPU_RM_DOWN, 5);

        // Reset pulse while the operation is shifting
        in_float = 32'h3FC0_0000; in_signed = 1'b1; in_round_mode = FPU_RM_EVEN; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("midshift_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        chk("midshift_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("midshift_rst_result", out_result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (30) begin
            @(posedge clk); #1;
        end
        chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_idle", {31'd0, in_ready}, 32'd1);

        // Randomized operands, exponents biased towards the interesting range
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 9) == 0) ex8 = 8'($urandom_range(0, 255));
            else                           ex8 = 8'($urandom_range(118, 162));
            mant = 23'($urandom);
            if ($urandom_range(0, 3) == 0) mant = mant & 23'h7C_0000;
            f = {1'($urandom_range(0, 1)), ex8, mant};
            m = fpu_round_mode_t'(2'($urandom_range(0, 3)));
            run_op(f, 1'($urandom_range(0, 1)), m, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
